// File: rtl/dds_config_sequencer.sv
// Receives 7-byte UART configuration frames for a DDS, validates them, and applies
// the held configuration only at a phase-accumulator wrap so waveforms switch glitch-free.
module dds_config_sequencer #(
    parameter int TIMEOUT_CYCLES = 1250000,
    parameter int FULL_SCALE     = 3300,
    parameter int RST_M          = 1,
    parameter int RST_OFFSET     = 1650
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        phase_wrap,
    output logic [1:0]  signal_type,
    output logic [15:0] tuning_M,
    output logic [15:0] offset,
    output logic [15:0] amplitude,
    output logic        cfg_update,
    output logic        frame_error,
    output logic        busy
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_CHECK
    } state_t;

    state_t r_state;
    state_t w_stateNext;

    logic [7:0]    r_bytes [0:6];
    logic [2:0]    r_cnt;
    logic [TW-1:0] r_tmo;

    logic          r_pending;
    logic [1:0]    r_pendType;
    logic [15:0]   r_pendM;
    logic [15:0]   r_pendOffset;
    logic [15:0]   r_pendAmp;

    logic [1:0]    r_signalType;
    logic [15:0]   r_tuningM;
    logic [15:0]   r_offset;
    logic [15:0]   r_amplitude;
    logic          r_cfgUpdate;
    logic          r_frameError;
    logic          r_busy;

    logic [7:0]    w_type;
    logic [15:0]   w_m;
    logic [15:0]   w_off;
    logic [15:0]   w_amp;
    logic [16:0]   w_sum;
    logic          w_frameOk;
    logic          w_timeout;
    logic          w_accept;
    logic          w_reject;
    logic          w_apply;
    logic          w_pendingNext;

    assign w_type = r_bytes[0];
    assign w_m    = {r_bytes[1], r_bytes[2]};
    assign w_off  = {r_bytes[3], r_bytes[4]};
    assign w_amp  = {r_bytes[5], r_bytes[6]};
    // The sum is widened to 17 bits so a large offset+amplitude cannot wrap past the limit.
    assign w_sum  = {1'b0, w_off} + {1'b0, w_amp};

    assign w_frameOk = (w_type <= 8'd2) && (w_m != 16'd0) && (w_amp <= w_off)
                       && (w_sum <= 17'(FULL_SCALE));

    assign w_timeout     = (r_state == S_RECV) && !rx_valid && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
    assign w_accept      = (r_state == S_CHECK) && w_frameOk;
    assign w_reject      = (r_state == S_CHECK) && !w_frameOk;
    assign w_apply       = r_pending && phase_wrap;
    assign w_pendingNext = w_accept || (r_pending && !w_apply);

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE:  if (rx_valid) w_stateNext = S_RECV;
            S_RECV: begin
                if (rx_valid && (r_cnt == 3'd6)) begin
                    w_stateNext = S_CHECK;
                end else if (w_timeout) begin
                    w_stateNext = S_IDLE;
                end
            end
            S_CHECK: w_stateNext = S_IDLE;
            default: w_stateNext = S_IDLE;
        endcase
    end

    // Byte capture and inter-byte timeout; bytes arriving during CHECK are dropped.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 7; i++) begin
                r_bytes[i] <= 8'd0;
            end
            r_cnt <= 3'd0;
            r_tmo <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tmo <= '0;
                    if (rx_valid) begin
                        r_bytes[0] <= rx_data;
                        r_cnt      <= 3'd1;
                    end
                end
                S_RECV: begin
                    if (rx_valid) begin
                        r_bytes[r_cnt] <= rx_data;
                        r_cnt          <= r_cnt + 3'd1;
                        r_tmo          <= '0;
                    end else if (w_timeout) begin
                        r_cnt <= 3'd0;
                        r_tmo <= '0;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                default: begin
                    r_cnt <= 3'd0;
                    r_tmo <= '0;
                end
            endcase
        end
    end

    // Apply reads the old pending values while a same-cycle accept overwrites them.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_pending    <= 1'b0;
            r_pendType   <= 2'd0;
            r_pendM      <= 16'd0;
            r_pendOffset <= 16'd0;
            r_pendAmp    <= 16'd0;
            r_signalType <= 2'd0;
            r_tuningM    <= 16'(RST_M);
            r_offset     <= 16'(RST_OFFSET);
            r_amplitude  <= 16'd0;
            r_cfgUpdate  <= 1'b0;
            r_frameError <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_cfgUpdate  <= w_apply;
            r_frameError <= w_timeout || w_reject;
            r_pending    <= w_pendingNext;
            r_busy       <= (w_stateNext != S_IDLE) || w_pendingNext;
            if (w_apply) begin
                r_signalType <= r_pendType;
                r_tuningM    <= r_pendM;
                r_offset     <= r_pendOffset;
                r_amplitude  <= r_pendAmp;
            end
            if (w_accept) begin
                r_pendType   <= w_type[1:0];
                r_pendM      <= w_m;
                r_pendOffset <= w_off;
                r_pendAmp    <= w_amp;
            end
        end
    end

    assign signal_type = r_signalType;
    assign tuning_M    = r_tuningM;
    assign offset      = r_offset;
    assign amplitude   = r_amplitude;
    assign cfg_update  = r_cfgUpdate;
    assign frame_error = r_frameError;
    assign busy        = r_busy;

endmodule

// File: tb/tb_dds_config_sequencer.sv
// Directed bench for dds_config_sequencer: frames, rejects, timeout, coalescing, reset and
// the same-cycle accept/apply case, with expected values worked out by hand.
module tb_dds_config_sequencer;

    logic        sysclk;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        phase_wrap;
    logic [1:0]  signal_type;
    logic [15:0] tuning_M;
    logic [15:0] offset;
    logic [15:0] amplitude;
    logic        cfg_update;
    logic        frame_error;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cfgPulses = 0;
    int errPulses = 0;

    dds_config_sequencer #(
        .TIMEOUT_CYCLES(1000),
        .FULL_SCALE(3300),
        .RST_M(1),
        .RST_OFFSET(1650)
    ) dut (
        .sysclk(sysclk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .phase_wrap(phase_wrap),
        .signal_type(signal_type),
        .tuning_M(tuning_M),
        .offset(offset),
        .amplitude(amplitude),
        .cfg_update(cfg_update),
        .frame_error(frame_error),
        .busy(busy)
    );

    initial sysclk = 1'b0;
    always #4 sysclk = ~sysclk;

    // Pulse counters sampled on the falling edge, away from the DUT's active edge.
    always @(negedge sysclk) begin
        if (cfg_update) cfgPulses++;
        if (frame_error) errPulses++;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    // Sends one 7-byte frame back to back; returns on the falling edge after the last byte.
    task automatic applyStimulus(input logic [55:0] frame);
        for (int i = 0; i < 7; i++) begin
            rx_data  = frame[8*(6-i) +: 8];
            rx_valid = 1'b1;
            @(negedge sysclk);
        end
        rx_valid = 1'b0;
    endtask

    task automatic pulseWrap();
        phase_wrap = 1'b1;
        @(negedge sysclk);
        phase_wrap = 1'b0;
    endtask

    task automatic checkConfig(input string tag, input int t, input int m, input int off, input int amp);
        checkOutput({tag, ".type"}, 32'(signal_type), 32'(t));
        checkOutput({tag, ".M"},    32'(tuning_M),    32'(m));
        checkOutput({tag, ".off"},  32'(offset),      32'(off));
        checkOutput({tag, ".amp"},  32'(amplitude),   32'(amp));
    endtask

    logic [55:0] rejects [4];
    int cfgBefore;
    int errBefore;
    int cycles;
    bit seen;

    initial begin
        rejects[0] = 56'h03_0064_0672_03E8;
        rejects[1] = 56'h01_0000_0672_03E8;
        rejects[2] = 56'h01_0064_0672_07D0;
        rejects[3] = 56'h01_0064_0BB8_01F4;

        reset = 1'b1;
        rx_data = 8'd0;
        rx_valid = 1'b0;
        phase_wrap = 1'b0;
        waitCycles(3);
        reset = 1'b0;
        waitCycles(2);

        $display("[TB] reset state");
        checkConfig("reset", 0, 1, 1650, 0);
        checkOutput("reset.busy", 32'(busy), 0);
        checkOutput("reset.cfg", 32'(cfg_update), 0);
        checkOutput("reset.ferr", 32'(frame_error), 0);

        $display("[TB] basic frame, wrap 100 cycles later");
        cfgBefore = cfgPulses;
        applyStimulus(56'h01_0064_0672_03E8);
        waitCycles(100);
        checkConfig("prewrap", 0, 1, 1650, 0);
        checkOutput("prewrap.busy", 32'(busy), 1);
        checkOutput("prewrap.cfgcount", 32'(cfgPulses - cfgBefore), 0);
        pulseWrap();
        waitCycles(4);
        checkConfig("applied", 1, 100, 1650, 1000);
        checkOutput("applied.cfgcount", 32'(cfgPulses - cfgBefore), 1);
        checkOutput("applied.busy", 32'(busy), 0);

        $display("[TB] rejected frames");
        for (int i = 0; i < 4; i++) begin
            errBefore = errPulses;
            cfgBefore = cfgPulses;
            applyStimulus(rejects[i]);
            waitCycles(4);
            pulseWrap();
            waitCycles(3);
            checkOutput($sformatf("reject%0d.ferr", i), 32'(errPulses - errBefore), 1);
            checkOutput($sformatf("reject%0d.cfg", i), 32'(cfgPulses - cfgBefore), 0);
            checkConfig($sformatf("reject%0d", i), 1, 100, 1650, 1000);
            checkOutput($sformatf("reject%0d.busy", i), 32'(busy), 0);
        end

        $display("[TB] full-scale boundary accepted");
        errBefore = errPulses;
        applyStimulus(56'h02_000A_0672_0672);
        waitCycles(3);
        pulseWrap();
        waitCycles(3);
        checkConfig("fullscale", 2, 10, 1650, 1650);
        checkOutput("fullscale.ferr", 32'(errPulses - errBefore), 0);

        $display("[TB] timeout after three bytes");
        errBefore = errPulses;
        for (int i = 0; i < 3; i++) begin
            rx_data  = (i == 0) ? 8'h01 : ((i == 1) ? 8'h00 : 8'h64);
            rx_valid = 1'b1;
            @(negedge sysclk);
        end
        rx_valid = 1'b0;
        cycles = 0;
        seen = 1'b0;
        while (!seen && cycles < 2000) begin
            @(negedge sysclk);
            cycles++;
            if (frame_error) seen = 1'b1;
        end
        checkOutput("timeout.seen", 32'(seen), 1);
        checkOutput("timeout.cycle", 32'(cycles), 1000);
        waitCycles(3);
        checkOutput("timeout.count", 32'(errPulses - errBefore), 1);
        checkOutput("timeout.busy", 32'(busy), 0);
        checkConfig("timeout", 2, 10, 1650, 1650);
        applyStimulus(56'h02_0064_0672_03E8);
        waitCycles(3);
        pulseWrap();
        waitCycles(3);
        checkConfig("aftertimeout", 2, 100, 1650, 1000);

        $display("[TB] two frames coalesce into one apply");
        cfgBefore = cfgPulses;
        applyStimulus(56'h01_00C8_0672_01F4);
        waitCycles(3);
        applyStimulus(56'h02_012C_05DC_03E8);
        waitCycles(3);
        checkConfig("coalesce.pre", 2, 100, 1650, 1000);
        pulseWrap();
        waitCycles(3);
        checkConfig("coalesce", 2, 300, 1500, 1000);
        checkOutput("coalesce.cfgcount", 32'(cfgPulses - cfgBefore), 1);
        checkOutput("coalesce.busy", 32'(busy), 0);
        pulseWrap();
        waitCycles(3);
        checkOutput("idlewrap.cfgcount", 32'(cfgPulses - cfgBefore), 1);

        $display("[TB] reset after byte 4");
        cfgBefore = cfgPulses;
        errBefore = errPulses;
        for (int i = 0; i < 4; i++) begin
            rx_data  = (i == 0) ? 8'h01 : ((i == 1) ? 8'h00 : ((i == 2) ? 8'h64 : 8'h06));
            rx_valid = 1'b1;
            @(negedge sysclk);
        end
        rx_valid = 1'b0;
        #2 reset = 1'b1;
        waitCycles(2);
        reset = 1'b0;
        waitCycles(3);
        checkConfig("midreset", 0, 1, 1650, 0);
        checkOutput("midreset.busy", 32'(busy), 0);
        checkOutput("midreset.cfg", 32'(cfgPulses - cfgBefore), 0);
        checkOutput("midreset.ferr", 32'(errPulses - errBefore), 0);
        applyStimulus(56'h01_0064_0672_03E8);
        waitCycles(3);
        pulseWrap();
        waitCycles(3);
        checkConfig("postreset", 1, 100, 1650, 1000);

        $display("[TB] wrap coincident with accept");
        applyStimulus(56'h02_012C_05DC_03E8);
        waitCycles(3);
        cfgBefore = cfgPulses;
        applyStimulus(56'h01_0032_0672_03E8);
        pulseWrap();
        waitCycles(3);
        checkConfig("coincident", 2, 300, 1500, 1000);
        checkOutput("coincident.busy", 32'(busy), 1);
        checkOutput("coincident.cfgcount", 32'(cfgPulses - cfgBefore), 1);
        pulseWrap();
        waitCycles(3);
        checkConfig("coincident.next", 1, 50, 1650, 1000);
        checkOutput("coincident.nextbusy", 32'(busy), 0);
        checkOutput("coincident.nextcount", 32'(cfgPulses - cfgBefore), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
